g1_chain_walker: RTL and testbench

G1_CHAIN_WALKER -- requirements
Module: g1_chain_walker

---
 rtl/g1_chain_walker_if.sv | 37 +++
 rtl/g1_chain_walker.sv | 106 ++++++++++
 tb/tb_g1_chain_walker.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/g1_chain_walker_if.sv
// Bundle of request, table-stage and response signals for the G1 chain walker.
// The slave view belongs to the walker; the master view belongs to its surroundings.
interface g1_chain_walker_if;
  logic         req_valid;
  logic         req_ready;
  logic [10:0]  req_index;
  logic [103:0] req_tuple;

  logic [10:0]  search_index;
  logic [103:0] tupleData;
  logic         tbl_match;
  logic [10:0]  tbl_ruleID;
  logic [10:0]  tbl_next_index;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_hit;
  logic [10:0]  rsp_ruleID;
  logic [4:0]   rsp_hops;
  logic         rsp_overflow;

  modport slave (
    input  req_valid, req_index, req_tuple,
    input  tbl_match, tbl_ruleID, tbl_next_index,
    input  rsp_ready,
    output req_ready, search_index, tupleData,
    output rsp_valid, rsp_hit, rsp_ruleID, rsp_hops, rsp_overflow
  );

  modport master (
    output req_valid, req_index, req_tuple,
    output tbl_match, tbl_ruleID, tbl_next_index,
    output rsp_ready,
    input  req_ready, search_index, tupleData,
    input  rsp_valid, rsp_hit, rsp_ruleID, rsp_hops, rsp_overflow
  );
endinterface

// File: rtl/g1_chain_walker.sv
// Walks a linked chain of G1 table entries for one header tuple, stopping on a
// rule match, a null next pointer, or after MAX_HOPS entries.
module g1_chain_walker #(
  parameter int          TABLE_LAT  = 2,
  parameter int          MAX_HOPS   = 16,
  parameter logic [10:0] NULL_INDEX = 11'h000
) (
  input logic              clk,
  input logic              rst_n,
  g1_chain_walker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, EVAL, DONE} state_t;

  localparam int             WW        = (TABLE_LAT > 1) ? $clog2(TABLE_LAT) : 1;
  localparam logic [WW-1:0]  WAIT_INIT = WW'(TABLE_LAT - 1);
  localparam logic [4:0]     HOP_LIMIT = 5'(MAX_HOPS);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [4:0]    hop_cnt;

  // WAIT holds for TABLE_LAT cycles so the EVAL cycle sees the table result
  // for the index loaded on the preceding accept/EVAL edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      hop_cnt          <= '0;
      bus.req_ready    <= 1'b1;
      bus.search_index <= '0;
      bus.tupleData    <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_hit      <= 1'b0;
      bus.rsp_ruleID   <= '0;
      bus.rsp_hops     <= '0;
      bus.rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.tupleData    <= bus.req_tuple;
            bus.search_index <= bus.req_index;
            hop_cnt          <= 5'd1;
            wait_cnt         <= WAIT_INIT;
            bus.req_ready    <= 1'b0;
            state            <= WAIT;
          end
        end

        WAIT: begin
          if (wait_cnt == '0) begin
            state <= EVAL;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        EVAL: begin
          if (bus.tbl_match) begin
            bus.rsp_hit      <= 1'b1;
            bus.rsp_ruleID   <= bus.tbl_ruleID;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_hops     <= hop_cnt;
            bus.rsp_valid    <= 1'b1;
            state            <= DONE;
          end else if (bus.tbl_next_index == NULL_INDEX) begin
            bus.rsp_hit      <= 1'b0;
            bus.rsp_ruleID   <= '0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_hops     <= hop_cnt;
            bus.rsp_valid    <= 1'b1;
            state            <= DONE;
          end else if (hop_cnt == HOP_LIMIT) begin
            bus.rsp_hit      <= 1'b0;
            bus.rsp_ruleID   <= '0;
            bus.rsp_overflow <= 1'b1;
            bus.rsp_hops     <= hop_cnt;
            bus.rsp_valid    <= 1'b1;
            state            <= DONE;
          end else begin
            bus.search_index <= bus.tbl_next_index;
            hop_cnt          <= hop_cnt + 5'd1;
            wait_cnt         <= WAIT_INIT;
            state            <= WAIT;
          end
        end

        DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_g1_chain_walker.sv
// Directed bench for g1_chain_walker: a table-stage model with TABLE_LAT
// pipeline delay, a vector table of chains, and hand-written corner sequences.
module tb_g1_chain_walker;

  localparam int          LAT   = 2;
  localparam int          HOPS  = 16;
  localparam logic [10:0] NULLI = 11'h000;
  localparam int          NV    = 9;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  g1_chain_walker_if bus ();

  g1_chain_walker #(
    .TABLE_LAT  (LAT),
    .MAX_HOPS   (HOPS),
    .NULL_INDEX (NULLI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Table-stage model: result reflects search_index from LAT edges earlier.
  logic        mem_match [2048];
  logic [10:0] mem_rule  [2048];
  logic [10:0] mem_next  [2048];
  logic [10:0] d1 = '0;
  logic [10:0] d2 = '0;

  always @(posedge clk) begin
    d1 <= bus.search_index;
    d2 <= d1;
  end

  assign bus.tbl_match      = mem_match[d2];
  assign bus.tbl_ruleID     = mem_rule[d2];
  assign bus.tbl_next_index = mem_next[d2];

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][10:0] idx;
    logic [3:0]       mt;
    logic [3:0][10:0] rule;
    logic [3:0][10:0] nxt;
    logic             e_hit;
    logic [10:0]      e_rule;
    logic [4:0]       e_hops;
    logic             e_ov;
  } vec_t;

  vec_t vecs [NV];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_tuple(input string nm, input logic [103:0] act, input logic [103:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 2048; i++) begin
      mem_match[i] = 1'b0;
      mem_rule[i]  = 11'(i);
      mem_next[i]  = NULLI;
    end
  endtask

  task automatic load_vec(input vec_t v);
    clear_tbl();
    for (int e = 0; e < 4; e++) begin
      if (e < int'(v.n)) begin
        mem_match[v.idx[e]] = v.mt[e];
        mem_rule[v.idx[e]]  = v.rule[e];
        mem_next[v.idx[e]]  = v.nxt[e];
      end
    end
  endtask

  function automatic logic [103:0] rnd_tuple();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Full lookup with rsp_ready held high; path[] holds the first npath indices visited.
  task automatic run_lookup(input string nm, input logic [10:0] head, input logic [3:0][10:0] path,
                            input int npath, input logic e_hit, input logic [10:0] e_rule,
                            input logic [4:0] e_hops, input logic e_ov);
    logic [103:0] tup;
    int cyc;
    int pi;
    tup = rnd_tuple();
    @(negedge clk);
    bus.req_index = head;
    bus.req_tuple = tup;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    chk($sformatf("%s_ready_idle", nm), 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_index = 11'h7ab;
    bus.req_tuple = rnd_tuple();
    chk_tuple($sformatf("%s_tuple", nm), bus.tupleData, tup);
    chk($sformatf("%s_ready_busy", nm), 32'(bus.req_ready), 32'd0);
    chk($sformatf("%s_path0", nm), 32'(bus.search_index), 32'(path[0]));
    cyc = 0;
    pi = 1;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.rsp_valid) break;
      if ((cyc % (LAT + 1)) == 0 && pi < npath) begin
        chk($sformatf("%s_path%0d", nm, pi), 32'(bus.search_index), 32'(path[pi]));
        pi++;
      end
    end
    chk($sformatf("%s_rsp_valid", nm), 32'(bus.rsp_valid), 32'd1);
    chk($sformatf("%s_latency", nm), 32'(cyc), 32'(int'(e_hops) * (LAT + 1)));
    chk($sformatf("%s_hit", nm), 32'(bus.rsp_hit), 32'(e_hit));
    chk($sformatf("%s_rule", nm), 32'(bus.rsp_ruleID), 32'(e_rule));
    chk($sformatf("%s_hops", nm), 32'(bus.rsp_hops), 32'(e_hops));
    chk($sformatf("%s_ovf", nm), 32'(bus.rsp_overflow), 32'(e_ov));
    @(posedge clk);
    #1;
    chk($sformatf("%s_rsp_drop", nm), 32'(bus.rsp_valid), 32'd0);
    chk($sformatf("%s_ready_back", nm), 32'(bus.req_ready), 32'd1);
  endtask

  logic [103:0] held_tuple;
  logic [3:0][10:0] ovf_path;
  int stuck;

  initial begin
    // Entries listed in visit order; {e3, e2, e1, e0}.
    vecs[0] = '{n: 3'd1, idx: {11'd0, 11'd0, 11'd0, 11'd5}, mt: 4'b0001,
                rule: {11'd0, 11'd0, 11'd0, 11'd42}, nxt: {4{NULLI}},
                e_hit: 1'b1, e_rule: 11'd42, e_hops: 5'd1, e_ov: 1'b0};
    vecs[1] = '{n: 3'd3, idx: {11'd0, 11'd12, 11'd9, 11'd5}, mt: 4'b0100,
                rule: {11'd0, 11'd7, 11'd3, 11'd4}, nxt: {11'd0, 11'd0, 11'd12, 11'd9},
                e_hit: 1'b1, e_rule: 11'd7, e_hops: 5'd3, e_ov: 1'b0};
    vecs[2] = '{n: 3'd2, idx: {11'd0, 11'd0, 11'd6, 11'd3}, mt: 4'b0000,
                rule: {11'd0, 11'd0, 11'h11, 11'h22}, nxt: {11'd0, 11'd0, NULLI, 11'd6},
                e_hit: 1'b0, e_rule: 11'd0, e_hops: 5'd2, e_ov: 1'b0};
    vecs[3] = '{n: 3'd1, idx: {11'd0, 11'd0, 11'd0, 11'd3}, mt: 4'b0000,
                rule: {11'd0, 11'd0, 11'd0, 11'h55}, nxt: {4{NULLI}},
                e_hit: 1'b0, e_rule: 11'd0, e_hops: 5'd1, e_ov: 1'b0};
    vecs[4] = '{n: 3'd1, idx: {11'd0, 11'd0, 11'd0, 11'd7}, mt: 4'b0001,
                rule: {11'd0, 11'd0, 11'd0, 11'd100}, nxt: {4{NULLI}},
                e_hit: 1'b1, e_rule: 11'd100, e_hops: 5'd1, e_ov: 1'b0};
    vecs[5] = '{n: 3'd1, idx: {11'd0, 11'd0, 11'd0, NULLI}, mt: 4'b0001,
                rule: {11'd0, 11'd0, 11'd0, 11'd55}, nxt: {4{NULLI}},
                e_hit: 1'b1, e_rule: 11'd55, e_hops: 5'd1, e_ov: 1'b0};
    vecs[6] = '{n: 3'd1, idx: {11'd0, 11'd0, 11'd0, NULLI}, mt: 4'b0000,
                rule: {11'd0, 11'd0, 11'd0, 11'd9}, nxt: {4{NULLI}},
                e_hit: 1'b0, e_rule: 11'd0, e_hops: 5'd1, e_ov: 1'b0};
    vecs[7] = '{n: 3'd4, idx: {11'd40, 11'd35, 11'd30, 11'd20}, mt: 4'b1000,
                rule: {11'h123, 11'h3ff, 11'd1, 11'd2}, nxt: {NULLI, 11'd40, 11'd35, 11'd30},
                e_hit: 1'b1, e_rule: 11'h123, e_hops: 5'd4, e_ov: 1'b0};
    vecs[8] = '{n: 3'd2, idx: {11'd0, 11'd0, 11'd22, 11'd21}, mt: 4'b0001,
                rule: {11'd0, 11'd0, 11'd6, 11'h7ff}, nxt: {11'd0, 11'd0, NULLI, 11'd22},
                e_hit: 1'b1, e_rule: 11'h7ff, e_hops: 5'd1, e_ov: 1'b0};

    clear_tbl();
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_index = '0;
    bus.req_tuple = '0;
    bus.rsp_ready = 1'b1;

    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_hit", 32'(bus.rsp_hit), 32'd0);
    chk("rst_rsp_rule", 32'(bus.rsp_ruleID), 32'd0);
    chk("rst_rsp_hops", 32'(bus.rsp_hops), 32'd0);
    chk("rst_rsp_ovf", 32'(bus.rsp_overflow), 32'd0);
    chk("rst_search_index", 32'(bus.search_index), 32'd0);
    chk_tuple("rst_tupleData", bus.tupleData, 104'd0);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      load_vec(vecs[k]);
      run_lookup($sformatf("v%0d", k), vecs[k].idx[0], vecs[k].idx, int'(vecs[k].n),
                 vecs[k].e_hit, vecs[k].e_rule, vecs[k].e_hops, vecs[k].e_ov);
    end

    // 20-entry cycle with no match must stop at MAX_HOPS.
    clear_tbl();
    for (int i = 0; i < 20; i++) begin
      mem_next[100 + i] = 11'(100 + ((i + 1) % 20));
      mem_rule[100 + i] = 11'(300 + i);
    end
    ovf_path = {11'd103, 11'd102, 11'd101, 11'd100};
    run_lookup("overflow", 11'd100, ovf_path, 4, 1'b0, 11'd0, 5'd16, 1'b1);

    // Consumer stalls: response held, no new request taken.
    load_vec(vecs[0]);
    held_tuple = rnd_tuple();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_index = 11'd5;
    bus.req_tuple = held_tuple;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    stuck = 0;
    while (!bus.rsp_valid && stuck < 50) begin
      @(posedge clk);
      #1;
      stuck++;
    end
    chk("stall_rsp_arrives", 32'(stuck), 32'd3);
    bus.req_valid = 1'b1;
    bus.req_index = 11'd9;
    bus.req_tuple = rnd_tuple();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_valid", c), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("stall%0d_hit", c), 32'(bus.rsp_hit), 32'd1);
      chk($sformatf("stall%0d_rule", c), 32'(bus.rsp_ruleID), 32'd42);
      chk($sformatf("stall%0d_hops", c), 32'(bus.rsp_hops), 32'd1);
      chk($sformatf("stall%0d_ready", c), 32'(bus.req_ready), 32'd0);
      chk_tuple($sformatf("stall%0d_tuple", c), bus.tupleData, held_tuple);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_valid", 32'(bus.rsp_valid), 32'd0);
    chk("stall_release_ready", 32'(bus.req_ready), 32'd1);
    chk_tuple("stall_release_tuple", bus.tupleData, held_tuple);

    // Reset while a 3-hop walk sits in WAIT.
    load_vec(vecs[1]);
    @(negedge clk);
    bus.req_index = 11'd5;
    bus.req_tuple = rnd_tuple();
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_search_index", 32'(bus.search_index), 32'd0);
    chk_tuple("midrst_tupleData", bus.tupleData, 104'd0);
    chk("midrst_rsp_hops", 32'(bus.rsp_hops), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_novalid%0d", c), 32'(bus.rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    run_lookup("post_rst", 11'd5, vecs[1].idx, 3, 1'b1, 11'd7, 5'd3, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_quiet%0d", c), 32'(bus.rsp_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
